// File: rtl/poly_compress_pkg.sv
// Shared constants, FSM state type and the debug probe struct for the
// poly_compress block (3-bit compression of a 512-coefficient polynomial).
package poly_compress_pkg;

    localparam int Q      = 12289;  // coefficient modulus
    localparam int N      = 512;    // coefficients per polynomial
    localparam int CBITS  = 3;      // compressed bits per coefficient
    localparam int Q_HALF = 6144;   // rounding offset added to 8x
    localparam int ADDR_W = 9;      // poly RAM address width
    localparam int COEF_W = 16;     // poly RAM data width
    localparam int GRP_W  = 6;      // 64 groups of 8 coefficients
    localparam int VAL_W  = 17;     // width of 8x + Q_HALF for x < Q

    // Last group index; its final read address is N-1.
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N / 8 - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_EMIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Snapshot of the control state, kept as one probe point for checkers.
    typedef struct packed {
        state_e           state;
        logic [3:0]       rd_idx;
        logic [1:0]       byte_idx;
        logic [GRP_W-1:0] grp;
    } dbg_t;

    // Compression threshold k*Q; t is the number of thresholds 8x+Q_HALF reaches.
    function automatic logic [VAL_W-1:0] thresh(input int unsigned k);
        return VAL_W'(k * Q);
    endfunction

endpackage

// File: rtl/poly_compress_coeff.sv
// Per-coefficient compressor: reduce the 14-bit coefficient once mod Q,
// then count how many thresholds k*Q (k=1..8) 8x+Q_HALF reaches. The low
// three bits of that count are floor((8x+Q_HALF)/Q) mod 8. One register stage.
module poly_compress_coeff
    import poly_compress_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [COEF_W-1:0] coef,
    output logic [CBITS-1:0]  t
);

    logic [13:0]      x_raw;
    logic [13:0]      x_red;
    logic [VAL_W-1:0] val;
    logic [CBITS-1:0] cnt;
    logic [1:0]       hi_unused;

    // The top two RAM bits carry no coefficient information.
    assign hi_unused = coef[15:14];

    // Reduce, scale, offset and count thresholds; a count of 8 wraps to 0.
    always_comb begin
        x_raw = coef[13:0];
        x_red = (x_raw >= 14'(Q)) ? (x_raw - 14'(Q)) : x_raw;
        val   = {x_red, 3'b000} + VAL_W'(Q_HALF);
        cnt   = '0;
        for (int unsigned k = 1; k <= 8; k++) begin
            if (val >= thresh(k)) begin
                cnt = cnt + CBITS'(1);
            end
        end
    end

    // Compress register stage, held while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= '0;
        end else if (en) begin
            t <= cnt;
        end
    end

endmodule

// File: rtl/poly_compress.sv
// Polynomial compressor: reads 512 coefficients from the poly RAM in groups
// of 8, compresses each to 3 bits and streams every group as 3 packed bytes.
//
// Handshake: dout_valid is high for the whole EMIT byte slot; a byte is
// transferred on a rising clk edge where en && dout_valid && dout_ready.
// dout/dout_valid never change until that transfer happens.
//
// The poly RAM read register is assumed to share the global en, so while en
// is low the RAM data, the compress stage and the packing register all hold
// and the read pipeline resumes without losing a coefficient.
module poly_compress
    import poly_compress_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr_out,
    input  logic [COEF_W-1:0] ram_doa,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready
);

    state_e           state;
    state_e           state_nxt;
    logic [3:0]       rd_idx;    // 0..7 issue addresses, 8..9 drain the pipeline
    logic [1:0]       byte_idx;  // which of the 3 packed bytes is presented
    logic [GRP_W-1:0] grp;       // current group of 8 coefficients
    logic [23:0]      pack;      // t7..t0, 3 bits each, t0 in the LSBs
    logic [CBITS-1:0] t_q;
    logic             accept;
    logic             read_last;
    logic             byte_last;
    logic             grp_last;
    dbg_t             dbg_unused;

    poly_compress_coeff u_coeff (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .coef (ram_doa),
        .t    (t_q)
    );

    assign accept    = dout_valid && dout_ready;
    assign read_last = (rd_idx == 4'd9);
    assign byte_last = (byte_idx == 2'd2);
    assign grp_last  = (grp == LAST_GRP);

    // Hierarchical probe of the control state; nothing in the design reads it.
    assign dbg_unused = '{state: state, rd_idx: rd_idx, byte_idx: byte_idx, grp: grp};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; bytes are plain slices of the packing
    // register because t0..t7 sit contiguously at 3 bits each.
    always_comb begin
        state_nxt  = state;
        done       = 1'b0;
        dout_valid = 1'b0;
        dout       = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (read_last) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                dout_valid = 1'b1;
                case (byte_idx)
                    2'd0:    dout = pack[7:0];
                    2'd1:    dout = pack[15:8];
                    default: dout = pack[23:16];
                endcase
                if (accept && byte_last) begin
                    state_nxt = grp_last ? ST_FINISH : ST_READ;
                end
            end
            ST_FINISH: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address, counters and packing register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx       <= '0;
            byte_idx     <= '0;
            grp          <= '0;
            pack         <= '0;
            ram_addr_out <= '0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rd_idx       <= '0;
                        byte_idx     <= '0;
                        grp          <= '0;
                        ram_addr_out <= '0;
                    end
                end
                ST_READ: begin
                    rd_idx <= read_last ? 4'd0 : (rd_idx + 4'd1);
                    // Address g*8+7 is issued at rd_idx 7 and then held.
                    if (rd_idx < 4'd7) begin
                        ram_addr_out <= ram_addr_out + ADDR_W'(1);
                    end
                    // Result of the address issued at rd_idx r lands at r+2.
                    for (int i = 0; i < 8; i++) begin
                        if (rd_idx == 4'(i + 2)) begin
                            pack[i*3 +: 3] <= t_q;
                        end
                    end
                end
                ST_EMIT: begin
                    if (accept) begin
                        if (byte_last) begin
                            byte_idx <= '0;
                            // After the last group the address stays at N-1.
                            if (!grp_last) begin
                                grp          <= grp + GRP_W'(1);
                                ram_addr_out <= ram_addr_out + ADDR_W'(1);
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_compress.sv
// Bench for poly_compress: RAM model, random/constant coefficient passes,
// expected-byte queue filled from an arithmetic reference, decoupled monitor.
module tb_poly_compress;

    localparam int QV = 12289;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic        done;
    logic [8:0]  ram_addr_out;
    logic [15:0] ram_doa;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;

    logic [15:0] mem [0:511];
    logic [7:0]  exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    bit ready_rand = 0;

    poly_compress dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start),
        .done         (done),
        .ram_addr_out (ram_addr_out),
        .ram_doa      (ram_doa),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready)
    );

    // ---------------- clock / reset / RAM ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Poly RAM: registered read, one cycle latency, shares the global enable.
    always @(posedge clk) begin
        if (en) ram_doa <= mem[ram_addr_out];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_t(input logic [15:0] w);
        int x;
        x = int'(w[13:0]);
        if (x >= QV) x = x - QV;
        return 3'(((8 * x + 6144) / QV) % 8);
    endfunction

    task automatic push_model();
        logic [2:0] t [8];
        int b0, b1, b2;
        for (int g = 0; g < 64; g++) begin
            for (int i = 0; i < 8; i++) t[i] = ref_t(mem[g*8 + i]);
            b0 = t[0] + t[1] * 8 + t[2] * 64;
            b1 = t[2] / 4 + t[3] * 2 + t[4] * 16 + t[5] * 128;
            b2 = t[5] / 2 + t[6] * 4 + t[7] * 32;
            exp_q.push_back(8'(b0));
            exp_q.push_back(8'(b1));
            exp_q.push_back(8'(b2));
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Ready driver: changes 1ns after each rising edge.
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dout_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic start_pass(output int c0);
        @(posedge clk);
        #1;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int c0, input int exp_lat, input int done0);
        int seen = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: done not seen within 4000 cycles");
        end else if (exp_lat > 0) begin
            chk("done_latency", seen - c0, exp_lat);
        end
        repeat (4) @(negedge clk);
        chk("done_pulses", done_cnt - done0, 1);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        bit         prev_hold = 0;
        logic [7:0] prev_dout = '0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 0;
            end else begin
                if (done) done_cnt++;
                if (en) begin
                    if (prev_hold) begin
                        chk("hold_valid", dout_valid, 1'b1);
                        chk("hold_data", dout, prev_dout);
                    end
                    if (dout_valid && dout_ready) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_byte: got 0x%0h with empty queue", dout);
                        end else begin
                            e = exp_q.pop_front();
                            chk("byte", dout, e);
                            acc_cnt++;
                        end
                    end
                    prev_hold = dout_valid && !dout_ready;
                    prev_dout = dout;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int c0, d0, a0;
        int thr [5] = '{768, 769, 6144, 12288, 12289};
        int ramp [8] = '{0, 1536, 3072, 4608, 6144, 7680, 9216, 10752};

        rst = 1'b1;
        en = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 8'h00);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", ram_addr_out, 9'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pass A: threshold values per group plus a t=0..7 ramp group;
        // a stray start mid-pass must be ignored.
        for (int g = 0; g < 64; g++)
            for (int i = 0; i < 8; i++)
                mem[g*8 + i] = 16'((g % 6 == 5) ? ramp[i] : thr[g % 6]);
        push_model();
        d0 = done_cnt;
        start_pass(c0);
        wait_cyc(c0 + 50);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(c0, 833, d0);

        // Pass B: all 6144 -> repeating 0x24 0x49 0x92, done 833 cycles after start.
        for (int i = 0; i < 512; i++) mem[i] = 16'd6144;
        for (int g = 0; g < 64; g++) begin
            exp_q.push_back(8'h24);
            exp_q.push_back(8'h49);
            exp_q.push_back(8'h92);
        end
        d0 = done_cnt;
        start_pass(c0);
        wait_done(c0, 833, d0);

        // Pass C: all 10752 (t=7) with random back-pressure.
        for (int i = 0; i < 512; i++) mem[i] = 16'd10752;
        for (int i = 0; i < 192; i++) exp_q.push_back(8'hFF);
        ready_rand = 1;
        d0 = done_cnt;
        a0 = acc_cnt;
        start_pass(c0);
        wait_done(c0, 0, d0);
        chk("byte_count", acc_cnt - a0, 192);
        ready_rand = 0;
        repeat (2) @(posedge clk);

        // Pass D: random data, reset during b1 of group 10, then a full rerun.
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom_range(0, 65535));
        push_model();
        d0 = done_cnt;
        a0 = acc_cnt;
        start_pass(c0);
        wait_cyc(c0 + 142);
        #1;
        chk("emit_before_rst", dout_valid, 1'b1);
        chk("accepted_before_rst", acc_cnt - a0, 31);
        rst = 1'b1;
        #1;
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_valid", dout_valid, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_addr", ram_addr_out, 9'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_partial_done", done_cnt - d0, 0);
        push_model();
        ready_rand = 1;
        d0 = done_cnt;
        a0 = acc_cnt;
        start_pass(c0);
        wait_done(c0, 0, d0);
        chk("rerun_count", acc_cnt - a0, 192);
        ready_rand = 0;
        repeat (2) @(posedge clk);

        // Pass E: random data, en low for 20 cycles at group 2 read slot 4.
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom_range(0, 65535));
        push_model();
        d0 = done_cnt;
        start_pass(c0);
        wait_cyc(c0 + 31);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("freeze_addr", ram_addr_out, 9'd20);
            chk("freeze_valid", dout_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
        wait_done(c0, 853, d0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
